// File: rtl/ps2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_pkg: shared PS/2 host-side types and cycle-count constants.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_state_t;

  localparam int unsigned TMR_W = 20;
  localparam logic [TMR_W-1:0] REQ_CYCLES = 20'd50;

  function automatic logic [TMR_W-1:0] us_to_cycles(input longint unsigned us,
                                                     input longint unsigned clk_hz);
    longint unsigned cyc;
    cyc = (us * clk_hz) / 64'd1_000_000;
    return cyc[TMR_W-1:0];
  endfunction

  // Default device-response timeout, also used by the receiver.
  localparam logic [TMR_W-1:0] TIMEOUT_CYCLES = us_to_cycles(64'd15000, 64'd50_000_000);

endpackage
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_line_sync: 2-flop synchronizer and falling-edge detect, 1 line.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pad,
  output logic level,
  output logic fall
);

  // [0] first stage, [1] synchronized level, [2] previous synchronized level
  logic [2:0] r_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh <= 3'b111;
    end else begin
      r_sh <= {r_sh[1:0], pad};
    end
  end

  assign level = r_sh[1];
  assign fall  = ~r_sh[1] & r_sh[2];

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_host_tx: host-to-device PS/2 command byte transmitter.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ps2_host_tx #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned INHIBIT_US = 100,
  parameter int unsigned TIMEOUT_US = 15000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);
  import ps2_pkg::*;

  localparam logic [TMR_W-1:0] INHIBIT_CYC = us_to_cycles(64'(INHIBIT_US), 64'(CLK_HZ));
  localparam logic [TMR_W-1:0] TIMEOUT_CYC = us_to_cycles(64'(TIMEOUT_US), 64'(CLK_HZ));

  logic clk_lvl, clk_fe, data_lvl, unused_data_fe;

  ps2_line_sync u_clk_sync (.clk(clk), .rst_n(rst_n), .pad(ps2_clk_i),
                            .level(clk_lvl), .fall(clk_fe));
  ps2_line_sync u_data_sync (.clk(clk), .rst_n(rst_n), .pad(ps2_data_i),
                             .level(data_lvl), .fall(unused_data_fe));

  ps2_state_t       r_state, w_state;
  logic [TMR_W-1:0] r_tmr, w_tmr;
  logic [3:0]       r_bitcnt, w_bitcnt;
  logic [9:0]       r_frame, w_frame;   // {stop, parity, data[7:0]}
  logic             w_clk_oe, w_data_oe, w_busy, w_done, w_error;

  always_comb begin
    w_state   = r_state;
    w_tmr     = r_tmr + 20'd1;
    w_bitcnt  = r_bitcnt;
    w_frame   = r_frame;
    w_clk_oe  = ps2_clk_oe;
    w_data_oe = ps2_data_oe;
    w_busy    = tx_busy;
    w_done    = 1'b0;
    w_error   = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_tmr     = '0;
        w_clk_oe  = 1'b0;
        w_data_oe = 1'b0;
        w_busy    = 1'b0;
        if (tx_start) begin
          w_frame  = {1'b1, ~^tx_data, tx_data};
          w_bitcnt = '0;
          w_clk_oe = 1'b1;
          w_busy   = 1'b1;
          w_state  = INHIBIT;
        end
      end
      INHIBIT: begin
        if (r_tmr == INHIBIT_CYC - 20'd1) begin
          w_tmr     = '0;
          w_data_oe = 1'b1;
          w_state   = REQ;
        end
      end
      REQ: begin
        if (r_tmr == REQ_CYCLES - 20'd1) begin
          w_tmr    = '0;
          w_clk_oe = 1'b0;
          w_state  = SHIFT;
        end
      end
      SHIFT: begin
        if (clk_fe) begin
          w_tmr     = '0;
          w_data_oe = ~r_frame[r_bitcnt];
          w_bitcnt  = r_bitcnt + 4'd1;
          if (r_bitcnt == 4'd9) w_state = ACK;
        end
      end
      ACK: begin
        if (clk_fe) begin
          w_tmr = '0;
          if (!data_lvl) begin
            w_state = WAIT_IDLE;
          end else begin
            w_error   = 1'b1;
            w_busy    = 1'b0;
            w_clk_oe  = 1'b0;
            w_data_oe = 1'b0;
            w_state   = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (clk_lvl && data_lvl) begin
          w_done  = 1'b1;
          w_busy  = 1'b0;
          w_state = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase

    // Device stalled: only counts while staying in a device-paced state.
    if ((r_state == SHIFT || r_state == ACK || r_state == WAIT_IDLE) &&
        (w_state == r_state) && (w_tmr == TIMEOUT_CYC)) begin
      w_error   = 1'b1;
      w_busy    = 1'b0;
      w_clk_oe  = 1'b0;
      w_data_oe = 1'b0;
      w_state   = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_tmr       <= '0;
      r_bitcnt    <= '0;
      r_frame     <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_tmr       <= w_tmr;
      r_bitcnt    <= w_bitcnt;
      r_frame     <= w_frame;
      ps2_clk_oe  <= w_clk_oe;
      ps2_data_oe <= w_data_oe;
      tx_busy     <= w_busy;
      tx_done     <= w_done;
      tx_error    <= w_error;
    end
  end

endmodule
`default_nettype wire
